// File: rtl/bus_target_responder.sv
// Target-side responder for the 65C02 bus: decodes an address window, forwards each
// access to a backing store over req/ack, and stalls the CPU with rdy until it completes.
module bus_target_responder #(
    parameter logic [15:0] BASE      = 16'h8000,
    parameter int          SIZE_LOG2 = 12,
    parameter int          TIMEOUT   = 15
) (
    input  logic        fclk,
    input  logic        reset,
    input  logic        phi2,
    input  logic        be,
    input  logic        rwb,
    input  logic [15:0] addr,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        data_oe,
    output logic        rdy,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic        timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_DRIVE,
        WR_CAP,
        WR_REQ
    } state_t;

    state_t           state;
    logic             phi2_q;
    logic             armed;
    logic [CNT_W-1:0] count;

    logic fall;
    logic start;
    logic hit;
    logic timed_out;

    assign fall      = ~phi2 & phi2_q;
    assign start     = (state == IDLE) & phi2_q & armed & be;
    assign hit       = (addr[15:SIZE_LOG2] == BASE[15:SIZE_LOG2]);
    assign timed_out = (count == TIMEOUT_CNT);

    // Output enable follows raw phi2 so the bus is released as soon as phi2 drops
    assign data_oe = (state == RD_DRIVE) & phi2 & be & rwb;

    always_ff @(posedge fclk) begin
        if (reset) begin
            state       <= IDLE;
            phi2_q      <= 1'b0;
            armed       <= 1'b1;
            count       <= '0;
            data_out    <= 8'h00;
            rdy         <= 1'b1;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= 16'h0000;
            mem_wdata   <= 8'h00;
            timeout_err <= 1'b0;
        end else begin
            phi2_q      <= phi2;
            timeout_err <= 1'b0;

            // One service per CPU cycle; re-arming at every fall lets a stretched cycle be retried
            if (fall) begin
                armed <= 1'b1;
            end else if (start) begin
                armed <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start && hit) begin
                        mem_addr <= addr;
                        count    <= '0;
                        if (rwb) begin
                            state   <= RD_WAIT;
                            mem_req <= 1'b1;
                            mem_we  <= 1'b0;
                            rdy     <= 1'b0;
                        end else begin
                            state <= WR_CAP;
                        end
                    end
                end

                RD_WAIT: begin
                    count <= count + CNT_W'(1);
                    if (mem_ack) begin
                        data_out <= mem_rdata;
                        mem_req  <= 1'b0;
                        rdy      <= 1'b1;
                        state    <= RD_DRIVE;
                    end else if (timed_out) begin
                        data_out    <= 8'hFF;
                        mem_req     <= 1'b0;
                        rdy         <= 1'b1;
                        timeout_err <= 1'b1;
                        state       <= RD_DRIVE;
                    end
                end

                RD_DRIVE: begin
                    if (fall) begin
                        state <= IDLE;
                    end
                end

                WR_CAP: begin
                    if (phi2_q) begin
                        mem_wdata <= data_in;
                    end
                    if (fall) begin
                        state   <= WR_REQ;
                        mem_req <= 1'b1;
                        mem_we  <= 1'b1;
                        rdy     <= 1'b0;
                        count   <= '0;
                    end
                end

                WR_REQ: begin
                    count <= count + CNT_W'(1);
                    if (mem_ack || timed_out) begin
                        state       <= IDLE;
                        mem_req     <= 1'b0;
                        mem_we      <= 1'b0;
                        rdy         <= 1'b1;
                        timeout_err <= ~mem_ack;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
